// File: rtl/vx_mem_rr_arbiter.sv
// vx_mem_rr_arbiter: shares one line-wide memory request/response port among
// NUM_REQS requesters. One transaction in flight at a time; the requester
// that wins round-robin arbitration owns the port until its response
// handshake completes.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req_*                 packed upstream requests, requester i in slice i
//   req_ready             one-hot accept back to the winner
//   rsp_valid/data/tag    response routed to the owner (data/tag broadcast)
//   rsp_ready             per-requester response ready
//   mem_req_*             downstream request (same-cycle pass-through)
//   mem_rsp_*             downstream response
//   busy                  high while a transaction is outstanding
//   owner                 current or last granted requester
//   timeout_err           sticky flag: response overdue by TIMEOUT_CYCLES
//   stray_rsp             one-cycle pulse after a response arrives while idle
module vx_mem_rr_arbiter #(
  parameter int unsigned NUM_REQS       = 4,
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned ADDR_WIDTH     = 26,
  parameter int unsigned TAG_WIDTH      = 56,
  parameter int unsigned BYTEEN_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              req_valid,
  input  logic [NUM_REQS-1:0]              req_rw,
  input  logic [NUM_REQS*BYTEEN_WIDTH-1:0] req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]    req_tag,
  output logic [NUM_REQS-1:0]              req_ready,
  output logic [NUM_REQS-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [TAG_WIDTH-1:0]             rsp_tag,
  input  logic [NUM_REQS-1:0]              rsp_ready,
  output logic                             mem_req_valid,
  output logic                             mem_req_rw,
  output logic [BYTEEN_WIDTH-1:0]          mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_data,
  output logic [TAG_WIDTH-1:0]             mem_req_tag,
  input  logic                             mem_req_ready,
  input  logic                             mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
  input  logic [TAG_WIDTH-1:0]             mem_rsp_tag,
  output logic                             mem_rsp_ready,
  output logic                             busy,
  output logic [$clog2(NUM_REQS)-1:0]      owner,
  output logic                             timeout_err,
  output logic                             stray_rsp
);

  localparam int unsigned OW = $clog2(NUM_REQS);
  localparam int unsigned SW = OW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t          state;
  logic [OW-1:0]   rr_ptr;
  logic [CW-1:0]   wait_cnt;
  logic [OW-1:0]   win;
  logic [SW-1:0]   idx;
  logic            found;

  logic [BYTEEN_WIDTH-1:0] byteen_a [NUM_REQS];
  logic [ADDR_WIDTH-1:0]   addr_a   [NUM_REQS];
  logic [DATA_WIDTH-1:0]   data_a   [NUM_REQS];
  logic [TAG_WIDTH-1:0]    tag_a    [NUM_REQS];

  // Unpack the flat request buses into per-requester arrays
  for (genvar g = 0; g < int'(NUM_REQS); g++) begin : g_unpack
    assign byteen_a[g] = req_byteen[g*BYTEEN_WIDTH +: BYTEEN_WIDTH];
    assign addr_a[g]   = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_a[g]   = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign tag_a[g]    = req_tag[g*TAG_WIDTH +: TAG_WIDTH];
  end

  // Round-robin search from rr_ptr upward; explicit wrap keeps it correct
  // for non-power-of-two NUM_REQS
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < int'(NUM_REQS); k++) begin
      idx = SW'(rr_ptr) + SW'(k);
      if (idx >= SW'(NUM_REQS)) idx = idx - SW'(NUM_REQS);
      if (!found && req_valid[idx[OW-1:0]]) begin
        found = 1'b1;
        win   = idx[OW-1:0];
      end
    end
  end

  // Port steering: request pass-through when idle, response routing in WAIT
  always_comb begin
    req_ready      = '0;
    rsp_valid      = '0;
    rsp_data       = '0;
    rsp_tag        = '0;
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_byteen = '0;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    mem_req_tag    = '0;
    mem_rsp_ready  = 1'b0;
    if (state == S_IDLE) begin
      // Anything arriving while idle belongs to nobody and is dropped
      mem_rsp_ready = mem_rsp_valid;
      if (found) begin
        mem_req_valid  = 1'b1;
        mem_req_rw     = req_rw[win];
        mem_req_byteen = byteen_a[win];
        mem_req_addr   = addr_a[win];
        mem_req_data   = data_a[win];
        mem_req_tag    = tag_a[win];
        req_ready[win] = mem_req_ready;
      end
    end else begin
      rsp_valid[owner] = mem_rsp_valid;
      rsp_data         = mem_rsp_data;
      rsp_tag          = mem_rsp_tag;
      mem_rsp_ready    = rsp_ready[owner];
    end
  end

  // Ownership FSM, round-robin pointer, watchdog and stray detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      stray_rsp   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      stray_rsp <= 1'b0;
      case (state)
        S_IDLE: begin
          stray_rsp <= mem_rsp_valid;
          if (mem_req_valid && mem_req_ready) begin
            owner    <= win;
            wait_cnt <= '0;
            busy     <= 1'b1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid && rsp_ready[owner]) begin
            rr_ptr <= (owner == OW'(NUM_REQS - 1)) ? '0 : owner + 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else if (!mem_rsp_valid && wait_cnt != CW'(TIMEOUT_CYCLES)) begin
            // Flag on the cycle the count reaches TIMEOUT_CYCLES; no abort
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_mem_rr_arbiter.sv
// Self-checking bench for vx_mem_rr_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_vx_mem_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 512;
  localparam int AW = 26;
  localparam int TW = 56;
  localparam int BW = DW / 8;
  localparam int TO = 8;

  logic              clk;
  logic              reset;
  logic [N-1:0]      req_valid, req_rw, req_ready, rsp_valid, rsp_ready;
  logic [N*BW-1:0]   req_byteen;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N*TW-1:0]   req_tag;
  logic [DW-1:0]     rsp_data;
  logic [TW-1:0]     rsp_tag;
  logic              mem_req_valid, mem_req_rw, mem_req_ready;
  logic [BW-1:0]     mem_req_byteen;
  logic [AW-1:0]     mem_req_addr;
  logic [DW-1:0]     mem_req_data;
  logic [TW-1:0]     mem_req_tag;
  logic              mem_rsp_valid, mem_rsp_ready;
  logic [DW-1:0]     mem_rsp_data;
  logic [TW-1:0]     mem_rsp_tag;
  logic              busy, timeout_err, stray_rsp;
  logic [1:0]        owner;

  vx_mem_rr_arbiter #(
    .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
    .BYTEEN_WIDTH(BW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_byteen(req_byteen),
    .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .busy(busy), .owner(owner), .timeout_err(timeout_err),
    .stray_rsp(stray_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-requester request fields kept by the bench
  logic          f_rw     [N];
  logic [BW-1:0] f_byteen [N];
  logic [AW-1:0] f_addr   [N];
  logic [DW-1:0] f_data   [N];
  logic [TW-1:0] f_tag    [N];

  // Transaction-level model
  bit    m_busy, m_to, m_stray;
  int    m_owner, m_ptr, m_wait;
  int    last_accept;
  int    grants[$];
  int    total, bad;
  string phase;

  function automatic int winner(int ptr, logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (v[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int j = 0; j < DW / 32; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_rw[i]                 = f_rw[i];
      req_byteen[i*BW +: BW]    = f_byteen[i];
      req_addr[i*AW +: AW]      = f_addr[i];
      req_data[i*DW +: DW]      = f_data[i];
      req_tag[i*TW +: TW]       = f_tag[i];
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_to = 0; m_stray = 0;
    m_owner = 0; m_ptr = 0; m_wait = 0;
  endtask

  task automatic check_all();
    int            w;
    bit            any;
    logic [N-1:0]  e_rdy, e_rv;
    any = (req_valid != '0) && !m_busy;
    w   = winner(m_ptr, req_valid);
    e_rdy = '0;
    e_rv  = '0;
    if (any) e_rdy[w] = mem_req_ready;
    if (m_busy) e_rv[m_owner] = mem_rsp_valid;
    chk("busy", DW'(busy), DW'(m_busy));
    chk("owner", DW'(owner), DW'(m_owner));
    chk("timeout_err", DW'(timeout_err), DW'(m_to));
    chk("stray_rsp", DW'(stray_rsp), DW'(m_stray));
    chk("mem_req_valid", DW'(mem_req_valid), DW'(any));
    chk("mem_req_rw", DW'(mem_req_rw), any ? DW'(f_rw[w]) : '0);
    chk("mem_req_byteen", DW'(mem_req_byteen), any ? DW'(f_byteen[w]) : '0);
    chk("mem_req_addr", DW'(mem_req_addr), any ? DW'(f_addr[w]) : '0);
    chk("mem_req_data", mem_req_data, any ? f_data[w] : '0);
    chk("mem_req_tag", DW'(mem_req_tag), any ? DW'(f_tag[w]) : '0);
    chk("req_ready", DW'(req_ready), DW'(e_rdy));
    chk("rsp_valid", DW'(rsp_valid), DW'(e_rv));
    chk("rsp_data", rsp_data, m_busy ? mem_rsp_data : '0);
    chk("rsp_tag", DW'(rsp_tag), m_busy ? DW'(mem_rsp_tag) : '0);
    chk("mem_rsp_ready", DW'(mem_rsp_ready),
        m_busy ? DW'(rsp_ready[m_owner]) : DW'(mem_rsp_valid));
  endtask

  // Settle current inputs and compare every output
  task automatic look();
    drive();
    #2;
    check_all();
  endtask

  // Apply the spec rules for one clock edge, then move past the edge
  task automatic advance();
    int w;
    last_accept = -1;
    for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
    w = winner(m_ptr, req_valid);
    if (!m_busy) begin
      m_stray = mem_rsp_valid;
      if (req_valid != '0 && mem_req_ready) begin
        m_busy = 1; m_owner = w; m_wait = 0; last_accept = w;
      end
    end else begin
      m_stray = 0;
      if (mem_rsp_valid && rsp_ready[m_owner]) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end else if (!mem_rsp_valid) begin
        m_wait++;
        if (m_wait >= TO) m_to = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; rsp_ready = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rsp_data = '0; mem_rsp_tag = '0;
    for (int i = 0; i < N; i++) begin
      f_rw[i] = 1'b0; f_byteen[i] = '0; f_addr[i] = '0;
      f_data[i] = '0; f_tag[i] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    look();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int exp_rr[5];
    total = 0; bad = 0;
    exp_rr = '{0, 1, 2, 3, 0};
    clear_inputs();

    phase = "reset";
    do_reset();
    look();

    phase = "single";
    f_addr[1] = AW'(26'h100); f_tag[1] = TW'(56'hA5); f_rw[1] = 1'b0;
    f_byteen[1] = '1; f_data[1] = rand_line();
    req_valid = 4'b0010; mem_req_ready = 1'b1;
    look();
    chk("single_addr", DW'(mem_req_addr), DW'(26'h100));
    advance();
    req_valid = '0; mem_req_ready = 1'b0;
    look();
    mem_rsp_valid = 1'b1; mem_rsp_data = rand_line();
    mem_rsp_tag = TW'(56'hA5); rsp_ready = 4'b0010;
    look();
    chk("single_rsp_valid", DW'(rsp_valid), DW'(4'b0010));
    advance();
    mem_rsp_valid = 1'b0; rsp_ready = '0;
    for (int i = 0; i < N; i++) begin
      f_addr[i] = AW'($urandom); f_tag[i] = TW'({$urandom, $urandom});
    end
    req_valid = 4'b1111;
    look();
    chk("ptr_after_1", DW'(req_ready), '0);
    mem_req_ready = 1'b1;
    look();
    chk("ptr_is_2", DW'(req_ready), DW'(4'b0100));
    mem_req_ready = 1'b0;

    phase = "round_robin";
    do_reset();
    grants.delete();
    req_valid = 4'b1111; mem_req_ready = 1'b1; rsp_ready = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      mem_rsp_valid = m_busy;
      mem_rsp_data  = rand_line();
      mem_rsp_tag   = TW'({$urandom, $urandom});
      look();
      advance();
    end
    chk("rr_count", DW'(grants.size()), DW'(5));
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk($sformatf("rr_grant%0d", i), DW'(grants[i]), DW'(exp_rr[i]));

    phase = "backpressure";
    clear_inputs();
    do_reset();
    req_valid = 4'b0100; mem_req_ready = 1'b1;
    look();
    advance();
    req_valid = 4'b1011;
    mem_rsp_valid = 1'b1; mem_rsp_data = rand_line(); mem_rsp_tag = TW'(7);
    rsp_ready = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      look();
      chk("bp_rsp_valid", DW'(rsp_valid), DW'(4'b0100));
      advance();
    end
    rsp_ready = 4'b1111;
    look();
    advance();
    mem_rsp_valid = 1'b0;
    look();
    chk("bp_next_grant", DW'(req_ready), DW'(4'b1000));
    mem_req_ready = 1'b0;

    phase = "timeout";
    clear_inputs();
    do_reset();
    req_valid = 4'b0001; mem_req_ready = 1'b1;
    look();
    advance();
    req_valid = '0; rsp_ready = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      look();
      chk($sformatf("to_cycle%0d", c), DW'(timeout_err), DW'(c >= TO));
      advance();
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = rand_line(); mem_rsp_tag = TW'(3);
    look();
    chk("late_rsp_valid", DW'(rsp_valid), DW'(4'b0001));
    advance();
    mem_rsp_valid = 1'b0;
    look();
    chk("to_sticky", DW'(timeout_err), DW'(1));

    phase = "stray";
    clear_inputs();
    do_reset();
    req_valid = 4'b0010; mem_req_ready = 1'b1;
    look();
    advance();
    req_valid = '0;
    look();
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    look();
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = rand_line(); mem_rsp_tag = TW'(9);
    rsp_ready = 4'b1111;
    look();
    chk("stray_drain", DW'(mem_rsp_ready), DW'(1));
    advance();
    mem_rsp_valid = 1'b0;
    look();
    chk("stray_pulse", DW'(stray_rsp), DW'(1));
    advance();
    look();
    chk("stray_end", DW'(stray_rsp), DW'(0));

    phase = "write";
    f_rw[3] = 1'b1; f_byteen[3] = '1; f_data[3] = {16{32'hDEADBEEF}};
    f_addr[3] = AW'($urandom); f_tag[3] = TW'({$urandom, $urandom});
    req_valid = 4'b1000; mem_req_ready = 1'b0;
    look();
    advance();
    mem_req_ready = 1'b1;
    look();
    chk("wr_data", mem_req_data, {16{32'hDEADBEEF}});
    chk("wr_byteen", DW'(mem_req_byteen), DW'({BW{1'b1}}));
    chk("wr_ready", DW'(req_ready), DW'(4'b1000));
    advance();

    phase = "random";
    clear_inputs();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (last_accept >= 0) req_valid[last_accept] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(2) == 0) begin
          req_valid[i] = 1'b1;
          f_rw[i]      = 1'($urandom);
          f_byteen[i]  = BW'({$urandom, $urandom});
          f_addr[i]    = AW'($urandom);
          f_data[i]    = rand_line();
          f_tag[i]     = TW'({$urandom, $urandom});
        end
      end
      mem_req_ready = ($urandom_range(3) != 0);
      mem_rsp_valid = m_busy ? 1'($urandom) : ($urandom_range(9) == 0);
      mem_rsp_data  = rand_line();
      mem_rsp_tag   = TW'({$urandom, $urandom});
      rsp_ready     = N'($urandom);
      look();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
